demux_collect_1b_128: RTL and testbench



---
 rtl/demux_collect_1b_128.sv | 86 ++++++++
 tb/tb_demux_collect_1b_128.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_collect_1b_128.sv
// Collects (bit, index) writes from a 1-to-NBITS demux stage into a word plus written-positions mask,
// emitted over val/rdy through one output register. Define DEMUX_COLLECT_DUPCHK_EN to add a sticky dup_err flag.
module demux_collect_1b_128 #(
  parameter  int NBITS = 128,
  localparam int SELW  = $clog2(NBITS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic             in_,
  input  logic [SELW-1:0]  in_sel,
  input  logic             in_last,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out_data,
`ifdef DEMUX_COLLECT_DUPCHK_EN
  output logic             dup_err,
`endif
  output logic [NBITS-1:0] out_mask
);

  logic [NBITS-1:0] accum;
  logic [NBITS-1:0] amask;
  logic [NBITS-1:0] onehot;
  logic [NBITS-1:0] next_data;
  logic [NBITS-1:0] next_mask;
  logic             accept;
  logic             complete;

  // Ready passes straight through from downstream: the output register can
  // take a new word in the same cycle its current word is being drained.
  assign in_rdy = !out_val || out_rdy;
  assign accept = in_val && in_rdy;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    onehot         = '0;
    onehot[in_sel] = 1'b1;
    next_data      = (accum & ~onehot) | (in_ ? onehot : '0);
    next_mask      = amask | onehot;
    complete       = accept && (in_last || (&next_mask));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accum    <= '0;
      amask    <= '0;
      out_data <= '0;
      out_mask <= '0;
      out_val  <= 1'b0;
    end else begin
      if (complete) begin
        // Accumulator returns to IDLE (amask == 0) on every completion.
        out_data <= next_data;
        out_mask <= next_mask;
        out_val  <= 1'b1;
        accum    <= '0;
        amask    <= '0;
      end else begin
        if (accept) begin
          accum <= next_data;
          amask <= next_mask;
        end
        if (out_val && out_rdy) begin
          out_val <= 1'b0;
        end
      end
    end
  end

`ifdef DEMUX_COLLECT_DUPCHK_EN
  // Sticky: only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dup_err <= 1'b0;
    end else if (accept && ((amask & onehot) != '0)) begin
      dup_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_collect_1b_128.sv
// Directed self-checking bench for demux_collect_1b_128: reset, full word, flush,
// backpressure/throughput, duplicate writes and asynchronous reset mid-word.
module tb_demux_collect_1b_128;

  localparam int NBITS = 128;

  logic             clk;
  logic             reset;
  logic             in_val;
  logic             in_rdy;
  logic             in_;
  logic [6:0]       in_sel;
  logic             in_last;
  logic             out_val;
  logic             out_rdy;
  logic [NBITS-1:0] out_data;
  logic [NBITS-1:0] out_mask;
`ifdef DEMUX_COLLECT_DUPCHK_EN
  logic             dup_err;
`endif

  int pass_cnt = 0;
  int total    = 0;

  demux_collect_1b_128 dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_      (in_),
    .in_sel   (in_sel),
    .in_last  (in_last),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_data (out_data),
`ifdef DEMUX_COLLECT_DUPCHK_EN
    .dup_err  (dup_err),
`endif
    .out_mask (out_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [NBITS-1:0] obs, input logic [NBITS-1:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One write, held across a rising edge; outputs are then sampled 1 time unit later.
  task automatic wr(input logic b, input int sel, input logic last);
    in_val  = 1'b1;
    in_     = b;
    in_sel  = sel[6:0];
    in_last = last;
    @(posedge clk);
    #1;
    in_val  = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [NBITS-1:0] exp_data;
  logic [NBITS-1:0] exp_mask;
  logic [NBITS-1:0] held_data;
  logic [NBITS-1:0] held_mask;

  initial begin
    reset   = 1'b0;
    in_val  = 1'b0;
    in_     = 1'b0;
    in_sel  = '0;
    in_last = 1'b0;
    out_rdy = 1'b1;

    // Reset values
    #12;
    chk("rst_out_val",  out_val,  '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_mask", out_mask, '0);
    chk("rst_in_rdy",   in_rdy,   1);
`ifdef DEMUX_COLLECT_DUPCHK_EN
    chk("rst_dup_err",  dup_err,  '0);
`endif
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Full word: indices 0..127 with in_ = sel[0]
    for (int i = 0; i < NBITS; i++) begin
      wr(i[0], i, 1'b0);
      if (i == 126) chk("full_no_early_val", out_val, '0);
    end
    chk("full_out_val",  out_val,  1);
    chk("full_out_data", out_data, {64{2'b10}});
    chk("full_out_mask", out_mask, {NBITS{1'b1}});
`ifdef DEMUX_COLLECT_DUPCHK_EN
    chk("full_no_dup",   dup_err,  '0);
`endif
    idle_cycle();
    chk("full_drained_val", out_val,  '0);
    chk("full_data_hold",   out_data, {64{2'b10}});

    // Early flush: (1,3) then (1,100) with in_last
    wr(1'b1, 3, 1'b0);
    chk("flush_pending_val", out_val, '0);
    wr(1'b1, 100, 1'b1);
    exp_data      = '0;
    exp_data[3]   = 1'b1;
    exp_data[100] = 1'b1;
    chk("flush_out_val",  out_val,  1);
    chk("flush_out_data", out_data, exp_data);
    chk("flush_out_mask", out_mask, exp_data);
    idle_cycle();
    chk("flush_drained_val", out_val, '0);

    // Backpressure: complete a word while downstream is not ready
    out_rdy = 1'b0;
    wr(1'b1, 5, 1'b0);
    wr(1'b0, 6, 1'b1);
    exp_data    = '0;
    exp_data[5] = 1'b1;
    exp_mask    = exp_data;
    exp_mask[6] = 1'b1;
    chk("bp_out_val",  out_val,  1);
    chk("bp_out_data", out_data, exp_data);
    chk("bp_out_mask", out_mask, exp_mask);
    held_data = exp_data;
    held_mask = exp_mask;
    // Offer a write during the hold; it must not be accepted.
    in_val  = 1'b1;
    in_     = 1'b1;
    in_sel  = 7'd9;
    in_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_in_rdy",    in_rdy,   '0);
      chk("bp_hold_val",  out_val,  1);
      chk("bp_hold_data", out_data, held_data);
      chk("bp_hold_mask", out_mask, held_mask);
      @(posedge clk);
      #1;
    end
    // Release together with a flush write (0,127)
    out_rdy = 1'b1;
    #1;
    chk("tp_in_rdy_pass", in_rdy, 1);
    wr(1'b0, 127, 1'b1);
    exp_mask      = '0;
    exp_mask[127] = 1'b1;
    chk("tp_out_val",  out_val,  1);
    chk("tp_out_data", out_data, '0);
    chk("tp_out_mask", out_mask, exp_mask);
    idle_cycle();
    chk("tp_drained_val", out_val, '0);

    // Duplicate write to index 15
    wr(1'b1, 15, 1'b0);
`ifdef DEMUX_COLLECT_DUPCHK_EN
    chk("dup_before", dup_err, '0);
`endif
    wr(1'b0, 15, 1'b0);
`ifdef DEMUX_COLLECT_DUPCHK_EN
    chk("dup_set", dup_err, 1);
`endif
    wr(1'b1, 0, 1'b1);
    exp_data     = '0;
    exp_data[0]  = 1'b1;
    exp_mask     = exp_data;
    exp_mask[15] = 1'b1;
    chk("dup_out_val",  out_val,  1);
    chk("dup_out_data", out_data, exp_data);
    chk("dup_out_mask", out_mask, exp_mask);
    idle_cycle();
`ifdef DEMUX_COLLECT_DUPCHK_EN
    chk("dup_sticky", dup_err, 1);
`endif

    // Asynchronous reset in the middle of a word
    for (int i = 0; i < 10; i++) begin
      wr(1'b1, 20 + i, 1'b0);
    end
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_val",  out_val,  '0);
    chk("arst_out_mask", out_mask, '0);
    chk("arst_in_rdy",   in_rdy,   1);
`ifdef DEMUX_COLLECT_DUPCHK_EN
    chk("arst_dup_clr",  dup_err,  '0);
`endif
    #1;
    reset = 1'b1;
    @(negedge clk);
    wr(1'b1, 7, 1'b1);
    exp_mask    = '0;
    exp_mask[7] = 1'b1;
    chk("arst_flush_val",  out_val,  1);
    chk("arst_flush_mask", out_mask, exp_mask);
    chk("arst_flush_data", out_data, exp_mask);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
